// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the execute-stage pipeline sequencing controller.
// Holds the controller state encoding and the width of the bubble counter.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_RUN    = 2'd0,
    CTRL_BUBBLE = 2'd1,
    CTRL_HOLD   = 2'd2
  } ctrl_state_t;

  // Wide enough for the largest post-redirect bubble run (7)
  localparam int BUBBLE_CNT_W = 3;

endpackage

// File: rtl/pipeline_flush_controller_sat_counter.sv
// Saturating up-counter used for the controller performance counters.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count qualified events, holding at the maximum value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_flush_controller.sv
// Stall/flush/redirect sequencing for fetch, decode and execute around the
// execute-stage conditional unit. Handles post-redirect bubble runs and
// defers redirects that resolve while the memory stage is busy.
// Optional build macro: PIPE_PERF_COUNTERS_EN enables the BranchCnt/StallCnt
// performance counters; without it both outputs are tied to zero.
module pipeline_flush_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             BranchTakenE,
  input  logic             PCSrcECU,
  input  logic             LoadUseD,
  input  logic             MemBusyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             RedirectF,
  output logic [1:0]       CtrlState,
  output logic [CNT_W-1:0] BranchCnt,
  output logic [CNT_W-1:0] StallCnt
);

  localparam logic [BUBBLE_CNT_W-1:0] BUB_LOAD   = BUBBLE_CNT_W'(REDIRECT_BUBBLES);
  localparam ctrl_state_t             REDIR_NEXT = (REDIRECT_BUBBLES > 0) ? CTRL_BUBBLE : CTRL_RUN;

  ctrl_state_t             state;
  ctrl_state_t             nextState;
  logic                    pend;
  logic                    nextPend;
  logic [BUBBLE_CNT_W-1:0] bubCnt;
  logic [BUBBLE_CNT_W-1:0] nextBubCnt;

  logic rd;
  logic doFreeze;
  logic doRedirect;
  logic doLoadUse;
  logic bubbleFlush;
  logic bubbleFreeze;

  logic stallF;
  logic stallD;
  logic stallE;
  logic flushD;
  logic flushE;
  logic redirectF;

  assign rd = BranchTakenE | PCSrcECU;

  // State, deferred-redirect flag and bubble counter; reset discards all of them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= CTRL_RUN;
      pend   <= 1'b0;
      bubCnt <= '0;
    end else begin
      state  <= nextState;
      pend   <= nextPend;
      bubCnt <= nextBubCnt;
    end
  end

  // Next-state logic and classification of this cycle's pipeline action
  always_comb begin
    nextState    = state;
    nextPend     = pend;
    nextBubCnt   = bubCnt;
    doFreeze     = 1'b0;
    doRedirect   = 1'b0;
    doLoadUse    = 1'b0;
    bubbleFlush  = 1'b0;
    bubbleFreeze = 1'b0;

    case (state)
      CTRL_RUN: begin
        // Memory freeze beats a redirect, which beats a wrong-path load-use
        if (MemBusyM) begin
          doFreeze  = 1'b1;
          nextPend  = rd;
          nextState = CTRL_HOLD;
        end else if (rd) begin
          doRedirect = 1'b1;
        end else if (LoadUseD) begin
          doLoadUse = 1'b1;
        end
      end

      CTRL_HOLD: begin
        if (MemBusyM) begin
          doFreeze = 1'b1;
          nextPend = pend | rd;
        end else begin
          // Leave on the falling cycle itself; a deferred redirect fires now
          nextPend  = 1'b0;
          nextState = CTRL_RUN;
          if (pend | rd) begin
            doRedirect = 1'b1;
          end else if (LoadUseD) begin
            doLoadUse = 1'b1;
          end
        end
      end

      CTRL_BUBBLE: begin
        // Execute holds a bubble, so rd and LoadUseD are not meaningful here
        bubbleFlush = 1'b1;
        if (MemBusyM) begin
          bubbleFreeze = 1'b1;
        end else begin
          nextBubCnt = bubCnt - BUBBLE_CNT_W'(1);
          if (bubCnt <= BUBBLE_CNT_W'(1)) begin
            nextState = CTRL_RUN;
          end
        end
      end

      default: begin
        nextState  = CTRL_RUN;
        nextPend   = 1'b0;
        nextBubCnt = '0;
      end
    endcase

    if (doRedirect) begin
      nextBubCnt = BUB_LOAD;
      nextState  = REDIR_NEXT;
    end
  end

  // Map actions onto stage controls; decode flush wins over stall in a bubble
  always_comb begin
    stallF    = doFreeze | doLoadUse | bubbleFreeze;
    stallD    = doFreeze | doLoadUse;
    stallE    = doFreeze | bubbleFreeze;
    flushD    = doRedirect | bubbleFlush;
    flushE    = doRedirect | doLoadUse;
    redirectF = doRedirect;
  end

  // Controls are forced quiet while reset is held, whatever the inputs do
  assign StallF    = rst_n & stallF;
  assign StallD    = rst_n & stallD;
  assign StallE    = rst_n & stallE;
  assign FlushD    = rst_n & flushD;
  assign FlushE    = rst_n & flushE;
  assign RedirectF = rst_n & redirectF;
  assign CtrlState = state;

`ifdef PIPE_PERF_COUNTERS_EN
  sat_counter #(.W(CNT_W)) uBranchCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (RedirectF),
    .count (BranchCnt)
  );

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (StallF),
    .count (StallCnt)
  );
`else
  assign BranchCnt = '0;
  assign StallCnt  = '0;
`endif

endmodule

// File: tb/tb_pipeline_flush_controller.sv
// Scoreboard bench for pipeline_flush_controller. Two instances run on the
// same inputs: one with one post-redirect bubble and a narrow counter, one
// with three bubbles and a full-width counter.
module tb_pipeline_flush_controller;

  typedef struct {
    logic [5:0] ctl;   // {StallF,StallD,StallE,FlushD,FlushE,RedirectF}
    logic [1:0] st;
    int         bc;
    int         sc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic bt    = 1'b0;
  logic pc    = 1'b0;
  logic lu    = 1'b0;
  logic mb    = 1'b0;

  always #5 clk = ~clk;

  wire        sF0, sD0, sE0, fD0, fE0, rF0;
  wire [1:0]  cs0;
  wire [3:0]  bc0, sc0;
  wire        sF1, sD1, sE1, fD1, fE1, rF1;
  wire [1:0]  cs1;
  wire [15:0] bc1, sc1;

  pipeline_flush_controller #(.REDIRECT_BUBBLES(1), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .BranchTakenE(bt), .PCSrcECU(pc), .LoadUseD(lu),
    .MemBusyM(mb), .StallF(sF0), .StallD(sD0), .StallE(sE0), .FlushD(fD0),
    .FlushE(fE0), .RedirectF(rF0), .CtrlState(cs0), .BranchCnt(bc0), .StallCnt(sc0)
  );

  pipeline_flush_controller #(.REDIRECT_BUBBLES(3), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .BranchTakenE(bt), .PCSrcECU(pc), .LoadUseD(lu),
    .MemBusyM(mb), .StallF(sF1), .StallD(sD1), .StallE(sE1), .FlushD(fD1),
    .FlushE(fE1), .RedirectF(rF1), .CtrlState(cs1), .BranchCnt(bc1), .StallCnt(sc1)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model: bubbles still owed, waiting on memory, redirect owed
  int bubLeft[2];
  bit waitMem[2];
  bit owed[2];
  int mBc[2];
  int mSc[2];
  int rbOf[2]  = '{1, 3};
  int maxOf[2] = '{15, 65535};

  function automatic exp_t modelStep(int k, bit b, bit p, bit l, bit m, bit r);
    exp_t e;
    bit rdv = b | p;
    bit sf = 0, sd = 0, se = 0, fd = 0, fe = 0, rf = 0;
    int st = 0;
    if (!r) begin
      bubLeft[k] = 0; waitMem[k] = 0; owed[k] = 0; mBc[k] = 0; mSc[k] = 0;
      e.ctl = '0; e.st = '0; e.bc = 0; e.sc = 0;
      return e;
    end
    e.bc = mBc[k];
    e.sc = mSc[k];
    if (bubLeft[k] > 0) begin
      st = 1; fd = 1;
      if (m) begin sf = 1; se = 1; end
      else bubLeft[k] = bubLeft[k] - 1;
    end else if (waitMem[k]) begin
      st = 2;
      if (m) begin
        sf = 1; sd = 1; se = 1; owed[k] = owed[k] | rdv;
      end else begin
        if (owed[k] | rdv) begin rf = 1; fd = 1; fe = 1; bubLeft[k] = rbOf[k]; end
        else if (l) begin sf = 1; sd = 1; fe = 1; end
        owed[k] = 0; waitMem[k] = 0;
      end
    end else begin
      st = 0;
      if (m) begin sf = 1; sd = 1; se = 1; owed[k] = rdv; waitMem[k] = 1; end
      else if (rdv) begin rf = 1; fd = 1; fe = 1; bubLeft[k] = rbOf[k]; end
      else if (l) begin sf = 1; sd = 1; fe = 1; end
    end
    if (rf && mBc[k] < maxOf[k]) mBc[k] = mBc[k] + 1;
    if (sf && mSc[k] < maxOf[k]) mSc[k] = mSc[k] + 1;
`ifndef PIPE_PERF_COUNTERS_EN
    e.bc = 0;
    e.sc = 0;
`endif
    e.ctl = {sf, sd, se, fd, fe, rf};
    e.st  = 2'(st);
    return e;
  endfunction

  task automatic cycle(input bit b, input bit p, input bit l, input bit m, input bit r);
    @(negedge clk);
    bt = b; pc = p; lu = l; mb = m; rst_n = r;
    q0.push_back(modelStep(0, b, p, l, m, r));
    q1.push_back(modelStep(1, b, p, l, m, r));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 1);
  endtask

  task automatic cmp(input int k, input exp_t e, input logic [5:0] ctl,
                     input logic [1:0] st, input int bc, input int sc);
    checks++;
    if (ctl !== e.ctl) begin
      errors++;
      $display("FAIL dut%0d cyc%0d controls got %b want %b", k, cyc, ctl, e.ctl);
    end
    checks++;
    if (st !== e.st) begin
      errors++;
      $display("FAIL dut%0d cyc%0d CtrlState got %0d want %0d", k, cyc, st, e.st);
    end
    checks++;
    if (bc != e.bc) begin
      errors++;
      $display("FAIL dut%0d cyc%0d BranchCnt got %0d want %0d", k, cyc, bc, e.bc);
    end
    checks++;
    if (sc != e.sc) begin
      errors++;
      $display("FAIL dut%0d cyc%0d StallCnt got %0d want %0d", k, cyc, sc, e.sc);
    end
  endtask

  // Monitor: outputs settle shortly after inputs change on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        cmp(0, e, {sF0, sD0, sE0, fD0, fE0, rF0}, cs0, int'(bc0), int'(sc0));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        cmp(1, e, {sF1, sD1, sE1, fD1, fE1, rF1}, cs1, int'(bc1), int'(sc1));
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic
  initial begin
    // Reset with busy inputs: every control must stay low
    cycle(1, 1, 1, 1, 0);
    cycle(1, 0, 1, 1, 0);
    cycle(0, 1, 0, 1, 0);
    idle(2);
    // Single taken branch
    cycle(1, 0, 0, 0, 1);
    idle(4);
    // Two load-use cycles
    cycle(0, 0, 1, 0, 1);
    cycle(0, 0, 1, 0, 1);
    idle(2);
    // Memory busy with a PC write deferred across it
    cycle(0, 1, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    idle(6);
    // Branch and load-use together
    cycle(1, 0, 1, 0, 1);
    idle(5);
    // Memory busy in the middle of a bubble run
    cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    idle(6);
    // Reset while holding with a redirect owed
    cycle(1, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    idle(5);
    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25,
            $urandom_range(0, 199) != 0);
    end
    idle(3);
    @(negedge clk);
    #3;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain queues left %0d/%0d want 0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_flush_controller.md
# pipeline_flush_controller

Sequencing controller for the pipeline around the execute-stage conditional unit. It consumes the resolved branch/PC-write decision, the load-use hazard request and the memory-busy indication. It produces the stall, flush and fetch-redirect controls for the fetch, decode and execute stages, including a configurable run of post-redirect bubbles and deferral of redirects across memory stalls. It sits beside the hazard logic, between the execute stage and the pipeline registers.

## Interface
- REDIRECT_BUBBLES, 1: extra decode-flush cycles after a redirect; legal range 0..7.
- CNT_W, 16: width of the performance counters.

- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- BranchTakenE  in  1  conditional branch resolved taken in execute
- PCSrcECU  in  1  condition-qualified PC write in execute
- LoadUseD  in  1  load-use hazard detected in decode
- MemBusyM  in  1  memory stage busy, pipeline must freeze
- StallF  out  1  hold fetch PC
- StallD  out  1  hold IF/ID register
- StallE  out  1  hold ID/EX register
- FlushD  out  1  clear IF/ID register
- FlushE  out  1  clear ID/EX register
- RedirectF  out  1  fetch selects the branch/PC target this cycle
- CtrlState  out  2  current FSM state encoding
- BranchCnt  out  CNT_W  redirects performed, saturating
- StallCnt  out  CNT_W  cycles with StallF=1, saturating

## Operation
- Redirect event: rd = BranchTakenE | PCSrcECU.
- Outputs are Mealy: combinational from state and inputs. Registers: state, pend, bub_cnt[2:0], counters.
- States: RUN=0, BUBBLE=1, HOLD=2. Encoding 3 is illegal and recovers to RUN.
- RUN, priority MemBusyM > rd > LoadUseD:
  - MemBusyM=1: StallF=StallD=StallE=1. pend <= rd. Next state HOLD.
  - rd=1: RedirectF=FlushD=FlushE=1. bub_cnt <= REDIRECT_BUBBLES. Next state is BUBBLE if REDIRECT_BUBBLES>0, else RUN. LoadUseD is ignored because it is wrong-path.
  - LoadUseD=1: StallF=StallD=1 and FlushE=1. Stay in RUN.
- HOLD:
  - While MemBusyM=1: StallF=StallD=StallE=1, and pend <= pend | rd.
  - On the first cycle with MemBusyM=0: if pend|rd, perform the RUN redirect actions, clear pend, then go to BUBBLE or RUN. Otherwise apply the RUN LoadUseD rule and go to RUN.
- BUBBLE:
  - FlushD=1 every cycle. rd and LoadUseD are ignored because execute holds a bubble.
  - MemBusyM=0: bub_cnt decrements. Exit to RUN on the cycle bub_cnt==1.
  - MemBusyM=1: StallF=StallE=1, FlushD=1 (flush wins over stall on decode), bub_cnt frozen.
- Never assert StallX and FlushX for the same stage in the same cycle, except for decode in BUBBLE, where FlushD wins and StallD=0.
- BranchCnt increments on each cycle RedirectF=1. StallCnt increments on each cycle StallF=1. Both saturate at all-ones.

## Timing
- Reset (rst_n=0, asynchronous): state=RUN, pend=0, bub_cnt=0, counters=0. Every output is 0, and CtrlState=0.
- Redirect latency is zero cycles: RedirectF, FlushD and FlushE assert in the same cycle as rd.
- Total decode flush cycles per redirect = 1 + REDIRECT_BUBBLES, excluding frozen cycles.
- Load-use response is a single cycle per LoadUseD cycle.
- HOLD exit is combinational on the MemBusyM falling cycle; there is no extra idle cycle.
- Reset asserted mid-BUBBLE or mid-HOLD discards pend and bub_cnt immediately.

## Configuration
- PIPE_PERF_COUNTERS_EN defined: BranchCnt and StallCnt are implemented as specified.
- PIPE_PERF_COUNTERS_EN undefined: no counter registers are instantiated, and BranchCnt and StallCnt are tied to 0.
- Control behaviour is identical in both builds.

## Structure
- Shared package pipeline_ctrl_pkg holds:
  - typedef enum logic [1:0] ctrl_state_t with CTRL_RUN, CTRL_BUBBLE, CTRL_HOLD;
  - localparam BUBBLE_CNT_W=3.
- One sub-module, sat_counter (parameter W; ports: clk, rst_n, inc, count). It is instantiated twice under the macro.

## Test plan
- Reset then BranchTakenE=1 for one cycle, REDIRECT_BUBBLES=1:
  - first cycle: RedirectF=FlushD=FlushE=1;
  - next cycle: FlushD=1 only, state BUBBLE;
  - then state RUN;
  - BranchCnt=1.
- LoadUseD=1 for 2 cycles in RUN: StallF=StallD=FlushE=1 on both cycles, StallCnt=2, RedirectF=0.
- MemBusyM=1 for 3 cycles with PCSrcECU pulsed in the first cycle only:
  - 3 cycles of StallF=StallD=StallE=1, with state RUN then HOLD;
  - redirect fires on the cycle MemBusyM falls.
- BranchTakenE and LoadUseD together in RUN: redirect outputs only, StallF=0.
- REDIRECT_BUBBLES=3 with MemBusyM=1 for 2 cycles during BUBBLE:
  - FlushD held for 1+3+2 cycles;
  - StallE=1 only during the 2 busy cycles.
- rst_n dropped mid-HOLD with pend=1:
  - outputs 0 immediately;
  - after release, no redirect occurs without a new rd.
